// File: rtl/pow_product_pipe.sv
// pow_product_pipe: three-stage pipelined power/product unit.
//   mode 0: c = a^4 * b^4    mode 1: c = a^2 * b^2
//   mode 2: c = a * b        mode 3: c = a^4
// Arithmetic is unsigned at full precision (8*W bits); c carries the low OW
// bits and ovf flags any nonzero bit above them.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   a, b, mode, in_valid     input item; in_ready accepts it
//   c, ovf, out_valid        output item; out_ready accepts it
//   result_cnt               wrapping count of output handshakes
module pow_product_pipe #(
  parameter int W  = 8,
  parameter int OW = 32,
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [W-1:0]  a,
  input  logic [W-1:0]  b,
  input  logic [1:0]    mode,
  input  logic          in_valid,
  output logic          in_ready,
  output logic [OW-1:0] c,
  output logic          ovf,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [CW-1:0] result_cnt
);

  typedef enum logic [1:0] {
    MODE_A4B4 = 2'd0,
    MODE_A2B2 = 2'd1,
    MODE_AB   = 2'd2,
    MODE_A4   = 2'd3
  } mode_e;

  localparam int PW = 8 * W;

  // S1
  logic            v1_q, v1_d;
  logic [W-1:0]    a1_q, a1_d, b1_q, b1_d;
  logic [2*W-1:0]  a2_q, a2_d, b2_q, b2_d;
  mode_e           mode1_q, mode1_d;
  // S2
  logic            v2_q, v2_d;
  logic [4*W-1:0]  x_q, x_d, y_q, y_d;
  // S3
  logic            v3_q, v3_d;
  logic [OW-1:0]   c_q, c_d;
  logic            ovf_q, ovf_d;
  // result counter
  logic [CW-1:0]   cnt_q, cnt_d;

  logic            stall;
  logic [PW-1:0]   p;

  assign stall      = v3_q && !out_ready;
  assign in_ready   = !stall;
  assign out_valid  = v3_q;
  assign c          = c_q;
  assign ovf        = ovf_q;
  assign result_cnt = cnt_q;

  always_comb begin
    v1_d    = v1_q;
    a1_d    = a1_q;
    b1_d    = b1_q;
    a2_d    = a2_q;
    b2_d    = b2_q;
    mode1_d = mode1_q;
    v2_d    = v2_q;
    x_d     = x_q;
    y_d     = y_q;
    v3_d    = v3_q;
    c_d     = c_q;
    ovf_d   = ovf_q;
    cnt_d   = cnt_q;
    p       = (PW)'(x_q) * (PW)'(y_q);

    if (out_valid && out_ready) begin
      cnt_d = cnt_q + CW'(1);
    end

    // Whole pipeline moves as one; a stall freezes every stage at once so
    // nothing is dropped or duplicated.
    if (!stall) begin
      v1_d    = in_valid;
      a1_d    = a;
      b1_d    = b;
      a2_d    = (2*W)'(a) * (2*W)'(a);
      b2_d    = (2*W)'(b) * (2*W)'(b);
      mode1_d = mode_e'(mode);

      v2_d = v1_q;
      unique case (mode1_q)
        MODE_A4B4: begin
          x_d = (4*W)'(a2_q) * (4*W)'(a2_q);
          y_d = (4*W)'(b2_q) * (4*W)'(b2_q);
        end
        MODE_A2B2: begin
          x_d = (4*W)'(a2_q);
          y_d = (4*W)'(b2_q);
        end
        MODE_AB: begin
          x_d = (4*W)'(a1_q);
          y_d = (4*W)'(b1_q);
        end
        MODE_A4: begin
          x_d = (4*W)'(a2_q) * (4*W)'(a2_q);
          y_d = (4*W)'(1);
        end
        default: begin
          x_d = '0;
          y_d = '0;
        end
      endcase

      v3_d  = v2_q;
      c_d   = p[OW-1:0];
      // Shifting by the full width yields zero, so OW == 8*W gives ovf = 0.
      ovf_d = |(p >> OW);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v1_q    <= 1'b0;
      a1_q    <= '0;
      b1_q    <= '0;
      a2_q    <= '0;
      b2_q    <= '0;
      mode1_q <= MODE_A4B4;
      v2_q    <= 1'b0;
      x_q     <= '0;
      y_q     <= '0;
      v3_q    <= 1'b0;
      c_q     <= '0;
      ovf_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      v1_q    <= v1_d;
      a1_q    <= a1_d;
      b1_q    <= b1_d;
      a2_q    <= a2_d;
      b2_q    <= b2_d;
      mode1_q <= mode1_d;
      v2_q    <= v2_d;
      x_q     <= x_d;
      y_q     <= y_d;
      v3_q    <= v3_d;
      c_q     <= c_d;
      ovf_q   <= ovf_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_pow_product_pipe.sv
// Bench for pow_product_pipe: a default instance (CW=16) and a CW=4 instance
// share all inputs; expected results are queued at input handshakes and
// compared at output handshakes.
module tb_pow_product_pipe;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  a = '0, b = '0;
  logic [1:0]  mode = '0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;

  logic        in_ready, ovf, out_valid;
  logic [31:0] c;
  logic [15:0] result_cnt;
  logic        in_ready_s, ovf_s, out_valid_s;
  logic [31:0] c_s;
  logic [3:0]  result_cnt_s;

  pow_product_pipe #(.W(8), .OW(32), .CW(16)) dut (
    .clk(clk), .rst(rst), .a(a), .b(b), .mode(mode), .in_valid(in_valid),
    .in_ready(in_ready), .c(c), .ovf(ovf), .out_valid(out_valid),
    .out_ready(out_ready), .result_cnt(result_cnt)
  );

  pow_product_pipe #(.W(8), .OW(32), .CW(4)) dut_s (
    .clk(clk), .rst(rst), .a(a), .b(b), .mode(mode), .in_valid(in_valid),
    .in_ready(in_ready_s), .c(c_s), .ovf(ovf_s), .out_valid(out_valid_s),
    .out_ready(out_ready), .result_cnt(result_cnt_s)
  );

  always #5 clk = ~clk;

  int          errors = 0;
  int          checks = 0;
  int          cnt_model = 0;
  int          stall_cnt = 0;
  bit          acc_flag = 0;
  bit          prev_stall = 0;
  logic [31:0] prev_c = '0;
  logic [32:0] sb[$];

  function automatic logic [63:0] model_p(input logic [7:0] ma, input logic [7:0] mb,
                                          input logic [1:0] mm);
    logic [63:0] aa, bb;
    aa = 64'(ma);
    bb = 64'(mb);
    case (mm)
      2'd0:    return aa * aa * aa * aa * bb * bb * bb * bb;
      2'd1:    return aa * aa * bb * bb;
      2'd2:    return aa * bb;
      default: return aa * aa * aa * aa;
    endcase
  endfunction

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Evaluated at the falling edge: decides what the coming rising edge does.
  task automatic sample();
    logic [32:0] e;
    logic [63:0] p;
    acc_flag = 0;
    check_eq("cnt", 64'(result_cnt), 64'(cnt_model[15:0]));
    check_eq("cnt_wrap", 64'(result_cnt_s), 64'(cnt_model[3:0]));
    if (prev_stall) begin
      check_eq("stall_hold_valid", 64'(out_valid), 64'd1);
      check_eq("stall_hold_c", 64'(c), 64'(prev_c));
    end
    if (rst) begin
      sb.delete();
      cnt_model  = 0;
      prev_stall = 0;
      return;
    end
    check_eq("in_ready", 64'(in_ready), 64'(!(out_valid && !out_ready)));
    check_eq("in_ready_s", 64'(in_ready_s), 64'(!(out_valid_s && !out_ready)));
    if (!in_ready) stall_cnt++;
    if (out_valid && out_ready) begin
      if (sb.size() == 0) begin
        check_eq("unexpected_out", 64'd1, 64'd0);
      end else begin
        e = sb.pop_front();
        check_eq("c", 64'(c), 64'(e[31:0]));
        check_eq("ovf", 64'(ovf), 64'(e[32]));
        check_eq("out_valid_s", 64'(out_valid_s), 64'd1);
        check_eq("c_s", 64'(c_s), 64'(e[31:0]));
        check_eq("ovf_s", 64'(ovf_s), 64'(e[32]));
      end
      cnt_model++;
    end
    if (in_valid && in_ready) begin
      p = model_p(a, b, mode);
      sb.push_back({|p[63:32], p[31:0]});
      acc_flag = 1;
    end
    prev_stall = out_valid && !out_ready;
    prev_c     = c;
  endtask

  task automatic tick();
    @(negedge clk);
    sample();
    @(posedge clk);
    #1;
  endtask

  task automatic randomize_item();
    a    = 8'($urandom_range(0, 255));
    b    = 8'($urandom_range(0, 255));
    mode = 2'($urandom_range(0, 3));
  endtask

  // One-cycle reset with a valid input presented, which must not be taken.
  task automatic do_reset();
    rst = 1'b1;
    in_valid = 1'b1;
    randomize_item();
    tick();
    rst = 1'b0;
    in_valid = 1'b0;
    check_eq("rst_out_valid", 64'(out_valid), 64'd0);
    check_eq("rst_c", 64'(c), 64'd0);
    check_eq("rst_ovf", 64'(ovf), 64'd0);
    check_eq("rst_cnt", 64'(result_cnt), 64'd0);
    check_eq("rst_in_ready", 64'(in_ready), 64'd1);
  endtask

  // Single item into an empty pipe; checks exact latency and a known result.
  task automatic directed(input logic [7:0] ta, input logic [7:0] tb_v, input logic [1:0] tm,
                          input logic [31:0] ec, input logic eo);
    a = ta; b = tb_v; mode = tm;
    in_valid = 1'b1;
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    randomize_item();
    tick();
    check_eq("lat_early", 64'(out_valid), 64'd0);
    tick();
    check_eq("lat_valid", 64'(out_valid), 64'd1);
    check_eq("dir_c", 64'(c), 64'(ec));
    check_eq("dir_ovf", 64'(ovf), 64'(eo));
    tick();
  endtask

  initial begin
    int sent;
    bit have;

    tick();
    do_reset();

    directed(8'd3, 8'd2, 2'd0, 32'h0000_0510, 1'b0);
    check_eq("cnt_after_first", 64'(result_cnt), 64'd1);
    directed(8'd255, 8'd255, 2'd0, 32'hC81B_F801, 1'b1);
    directed(8'd16, 8'd77, 2'd3, 32'h0001_0000, 1'b0);
    directed(8'd200, 8'd100, 2'd2, 32'd20000, 1'b0);

    // Back-to-back stream, one item per mode.
    for (int m = 0; m < 4; m++) begin
      a = 8'($urandom_range(0, 255));
      b = 8'($urandom_range(0, 255));
      mode = 2'(m);
      in_valid = 1'b1;
      tick();
      if (m >= 2) check_eq("b2b_valid", 64'(out_valid), 64'd1);
    end
    in_valid = 1'b0;
    tick();
    check_eq("b2b_valid", 64'(out_valid), 64'd1);
    tick();
    check_eq("b2b_valid", 64'(out_valid), 64'd1);
    tick();
    check_eq("b2b_end", 64'(out_valid), 64'd0);

    // Six items with a five-cycle output stall mid-stream.
    do_reset();
    sent = 0;
    have = 0;
    stall_cnt = 0;
    for (int t = 0; t < 30; t++) begin
      out_ready = !(t >= 4 && t < 9);
      if (sent < 6 && !have) begin
        randomize_item();
        have = 1;
      end
      in_valid = (sent < 6);
      tick();
      if (acc_flag) begin
        sent++;
        have = 0;
      end
    end
    in_valid = 1'b0;
    check_eq("stall_cycles", 64'(stall_cnt), 64'd5);
    check_eq("stall_cnt6", 64'(result_cnt), 64'd6);
    check_eq("stall_drained", 64'(sb.size()), 64'd0);

    // Reset with three items in flight.
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      randomize_item();
      in_valid = 1'b1;
      tick();
    end
    check_eq("midrst_busy", 64'(out_valid), 64'd1);
    do_reset();
    directed(8'd3, 8'd2, 2'd0, 32'h0000_0510, 1'b0);
    for (int i = 0; i < 6; i++) tick();
    check_eq("midrst_cnt", 64'(result_cnt), 64'd1);

    // Counter wrap on the CW=4 instance.
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 17; i++) begin
      randomize_item();
      in_valid = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    check_eq("wrap_cnt4", 64'(result_cnt_s), 64'd1);
    check_eq("wrap_cnt16", 64'(result_cnt), 64'd17);

    // Random traffic and backpressure, then drain.
    for (int i = 0; i < 80; i++) begin
      randomize_item();
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) tick();
    check_eq("rand_drained", 64'(sb.size()), 64'd0);
    check_eq("rand_idle", 64'(out_valid), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pow_product_pipe.md
POW_PRODUCT_PIPE -- requirements
Module: pow_product_pipe

Interface
REQ-001 Parameter W, default 8, operand width in bits (2..16).
REQ-002 Parameter OW, default 32, result width in bits (1..8*W).
REQ-003 Parameter CW, default 16, result-counter width in bits.
REQ-004 clk  input  1  sole clock, all state updates on rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 a  input  W  unsigned operand A.
REQ-007 b  input  W  unsigned operand B.
REQ-008 mode  input  2  operation select, sampled with a/b.
REQ-009 in_valid  input  1  a/b/mode valid this cycle.
REQ-010 in_ready  output  1  block accepts input this cycle.
REQ-011 c  output  OW  result, low OW bits of full-precision product.
REQ-012 ovf  output  1  full-precision result has nonzero bits above bit OW-1.
REQ-013 out_valid  output  1  c/ovf valid.
REQ-014 out_ready  input  1  consumer accepts result.
REQ-015 result_cnt  output  CW  count of completed output handshakes.

Function
REQ-016 Modes shall be: 0 -> a^4*b^4; 1 -> a^2*b^2; 2 -> a*b; 3 -> a^4.
REQ-017 All arithmetic shall be unsigned and full precision internally (8*W bits), no intermediate truncation.
REQ-018 Pipeline shall have exactly 3 register stages: S1 registers a, b, a^2, b^2, mode; S2 registers selected operands x, y (4*W bits each); S3 registers c, ovf.
REQ-019 S2 selection: mode 0 x=a^4, y=b^4; mode 1 x=a^2, y=b^2; mode 2 x=a, y=b; mode 3 x=a^4, y=1.
REQ-020 S3 shall compute p=x*y; c=p[OW-1:0]; ovf=OR of p[8*W-1:OW], or 0 when OW=8*W.
REQ-021 Transfer in occurs when in_valid and in_ready both high; transfer out when out_valid and out_ready both high.
REQ-022 stall shall equal out_valid AND NOT out_ready; in_ready shall equal NOT stall (combinational).
REQ-023 When stall is high, all stage registers and valid bits shall hold; no input accepted, no data lost or duplicated.
REQ-024 When stall is low, every stage advances one position per cycle; a stage with no incoming valid data becomes a bubble (valid 0).
REQ-025 Latency from input transfer to out_valid shall be 3 cycles with no stall; throughput one result per cycle with out_ready held high.
REQ-026 Results shall leave in acceptance order; c/ovf shall be stable while out_valid is high and out_ready low.
REQ-027 result_cnt shall increment by 1 on each output transfer and wrap from 2^CW-1 to 0.
REQ-028 Simultaneous input and output transfer in one cycle shall both complete.
REQ-029 mode values are held per item; a mode change between items shall not affect items already accepted.

Reset
REQ-030 While rst is high at a clock edge: all stage valid bits 0, out_valid=0, c=0, ovf=0, result_cnt=0.
REQ-031 in_ready shall be 1 in the cycle following reset deassertion; reset mid-operation shall discard all in-flight items, producing no output transfer for them.
REQ-032 Inputs presented while rst is high shall not be accepted.

Verification
REQ-033 W=8, OW=32, mode 0, a=3, b=2, out_ready=1 -> 3 cycles later out_valid=1, c=0x00000510, ovf=0, result_cnt then 1.
REQ-034 Mode 0, a=255, b=255 -> c=0xC81BF801, ovf=1; mode 3, a=16 -> c=0x00010000, ovf=0; mode 2, a=200, b=100 -> c=20000, ovf=0.
REQ-035 Back-to-back stream of 4 items (modes 0,1,2,3) with out_ready=1 -> 4 consecutive out_valid cycles, correct values in order.
REQ-036 Stream 6 items, out_ready low for 5 cycles mid-stream -> in_ready low exactly while stall, c held stable, all 6 results delivered in order, result_cnt=6.
REQ-037 Assert rst for 1 cycle with 3 items in flight -> out_valid=0, result_cnt=0 next cycle, none of the 3 items emerge; next item emerges after 3 cycles.
REQ-038 CW=4, 17 output transfers -> result_cnt reads 1 (wrapped via 15->0).
